// File: rtl/block_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : block_lock_fsm
// Brief    : 64b/66b block lock. Tests sync headers and requests gearbox
//            slips until 66-bit alignment is held.
// Revision : 1.0 - initial release
// ============================================================================
module block_lock_fsm #(
    parameter int SH_CNT_MAX = 64,
    parameter int INVLD_MAX  = 16,
    parameter int SLIP_WAIT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [65:0] rx_block_in,
    input  logic        rx_block_valid,
    output logic        slip,
    output logic        block_lock,
    output logic [65:0] block_out,
    output logic        block_out_valid
);

    localparam int WAIT_W = $clog2(SLIP_WAIT + 2);

    localparam logic [0:0] S_TEST      = 1'b0;
    localparam logic [0:0] S_SLIP_HOLD = 1'b1;

    localparam logic [6:0]        c_sh_cnt_max = 7'(SH_CNT_MAX);
    localparam logic [4:0]        c_invld_max  = 5'(INVLD_MAX);
    localparam logic [WAIT_W-1:0] c_slip_wait  = WAIT_W'(SLIP_WAIT);

    logic [0:0]        r_state;
    logic [6:0]        r_sh_cnt;
    logic [4:0]        r_invld_cnt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_lock;
    logic              r_slip;
    logic [65:0]       r_block_out;
    logic              r_block_out_valid;

    logic [0:0]        w_state_next;
    logic [6:0]        w_sh_cnt_next;
    logic [4:0]        w_invld_cnt_next;
    logic [WAIT_W-1:0] w_wait_cnt_next;
    logic              w_lock_next;
    logic              w_slip_next;

    logic              w_hdr_invalid;
    logic [6:0]        w_sh_inc;
    logic [4:0]        w_invld_inc;
    logic [WAIT_W-1:0] w_wait_inc;

    // A sync header is valid only when its two bits differ (01 or 10).
    assign w_hdr_invalid = ~(rx_block_in[1] ^ rx_block_in[0]);
    assign w_sh_inc      = r_sh_cnt + 7'd1;
    assign w_invld_inc   = r_invld_cnt + {4'd0, w_hdr_invalid};
    assign w_wait_inc    = r_wait_cnt + {{(WAIT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_TEST;
            r_sh_cnt          <= 7'd0;
            r_invld_cnt       <= 5'd0;
            r_wait_cnt        <= '0;
            r_lock            <= 1'b0;
            r_slip            <= 1'b0;
            r_block_out       <= 66'd0;
            r_block_out_valid <= 1'b0;
        end else begin
            r_state           <= w_state_next;
            r_sh_cnt          <= w_sh_cnt_next;
            r_invld_cnt       <= w_invld_cnt_next;
            r_wait_cnt        <= w_wait_cnt_next;
            r_lock            <= w_lock_next;
            r_slip            <= w_slip_next;
            r_block_out_valid <= rx_block_valid & r_lock;
            if (rx_block_valid) begin
                r_block_out <= rx_block_in;
            end
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_sh_cnt_next    = r_sh_cnt;
        w_invld_cnt_next = r_invld_cnt;
        w_wait_cnt_next  = r_wait_cnt;
        w_lock_next      = r_lock;
        w_slip_next      = 1'b0;
        if (rx_block_valid) begin
            case (r_state)
                S_TEST: begin
                    if ((!r_lock && w_hdr_invalid) ||
                        (r_lock && (w_invld_inc == c_invld_max))) begin
                        // Lock loss and first bad header while hunting both slip.
                        w_lock_next      = 1'b0;
                        w_slip_next      = 1'b1;
                        w_sh_cnt_next    = 7'd0;
                        w_invld_cnt_next = 5'd0;
                        w_wait_cnt_next  = '0;
                        w_state_next     = S_SLIP_HOLD;
                    end else if (w_sh_inc == c_sh_cnt_max) begin
                        w_sh_cnt_next    = 7'd0;
                        w_invld_cnt_next = 5'd0;
                        if (w_invld_inc == 5'd0) begin
                            w_lock_next = 1'b1;
                        end
                    end else begin
                        w_sh_cnt_next    = w_sh_inc;
                        w_invld_cnt_next = w_invld_inc;
                    end
                end
                S_SLIP_HOLD: begin
                    // Blocks here are still misaligned; discard them while the gearbox settles.
                    if (w_wait_inc >= c_slip_wait) begin
                        w_wait_cnt_next  = '0;
                        w_sh_cnt_next    = 7'd0;
                        w_invld_cnt_next = 5'd0;
                        w_state_next     = S_TEST;
                    end else begin
                        w_wait_cnt_next = w_wait_inc;
                    end
                end
                default: begin
                    w_state_next = S_TEST;
                end
            endcase
        end
    end

    always_comb begin
        slip            = r_slip;
        block_lock      = r_lock;
        block_out       = r_block_out;
        block_out_valid = r_block_out_valid;
    end

endmodule
`default_nettype wire

// File: tb/tb_block_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_lock_fsm
// Brief    : Scoreboard bench for block_lock_fsm against a cycle model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_lock_fsm;

    localparam int SH_CNT_MAX = 64;
    localparam int INVLD_MAX  = 16;
    localparam int SLIP_WAIT  = 2;

    localparam logic [1:0] c_hdr_good = 2'b10;
    localparam logic [1:0] c_hdr_alt  = 2'b01;
    localparam logic [1:0] c_hdr_bad0 = 2'b00;
    localparam logic [1:0] c_hdr_bad1 = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] rx_block_in = 66'd0;
    logic        rx_block_valid = 1'b0;
    logic        slip;
    logic        block_lock;
    logic [65:0] block_out;
    logic        block_out_valid;

    block_lock_fsm #(
        .SH_CNT_MAX (SH_CNT_MAX),
        .INVLD_MAX  (INVLD_MAX),
        .SLIP_WAIT  (SLIP_WAIT)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_block_in     (rx_block_in),
        .rx_block_valid  (rx_block_valid),
        .slip            (slip),
        .block_lock      (block_lock),
        .block_out       (block_out),
        .block_out_valid (block_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        slip;
        logic        lock;
        logic [65:0] out;
        logic        out_v;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   slip_seen = 0;

    // Reference model state
    bit          m_lock, m_hold;
    int          m_sh, m_inv, m_wait;
    logic [65:0] m_out;

    task automatic check_val(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lock = 0; m_hold = 0; m_sh = 0; m_inv = 0; m_wait = 0; m_out = 66'd0;
        sb_q.delete();
    endtask

    // One clock: drive inputs, push model expectation, pop and compare after the edge.
    task automatic step(input bit v, input logic [1:0] hdr);
        logic [95:0] rnd;
        logic [65:0] d;
        exp_t        e;
        exp_t        got;
        bit          bad;
        @(negedge clk);
        rnd = {$urandom(), $urandom(), $urandom()};
        d   = {rnd[65:2], hdr};
        rx_block_in    = d;
        rx_block_valid = v;
        e.out   = v ? d : m_out;
        e.out_v = v & m_lock;
        e.slip  = 1'b0;
        if (v) begin
            if (m_hold) begin
                m_wait++;
                if (m_wait >= SLIP_WAIT) begin
                    m_hold = 0; m_wait = 0; m_sh = 0; m_inv = 0;
                end
            end else begin
                bad = (hdr == 2'b00) || (hdr == 2'b11);
                m_sh++;
                if (bad) m_inv++;
                if ((!m_lock && bad) || (m_lock && m_inv == INVLD_MAX)) begin
                    m_lock = 0; e.slip = 1'b1; m_hold = 1; m_wait = 0; m_sh = 0; m_inv = 0;
                end else if (m_sh == SH_CNT_MAX) begin
                    if (m_inv == 0) m_lock = 1;
                    m_sh = 0; m_inv = 0;
                end
            end
        end
        e.lock = m_lock;
        m_out  = e.out;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("slip", {65'd0, slip}, {65'd0, got.slip});
        check_val("lock", {65'd0, block_lock}, {65'd0, got.lock});
        check_val("block_out", block_out, got.out);
        check_val("out_valid", {65'd0, block_out_valid}, {65'd0, got.out_v});
        if (slip) slip_seen++;
    endtask

    task automatic run_good(input int n);
        for (int i = 0; i < n; i++) step(1'b1, (i % 3 == 0) ? c_hdr_alt : c_hdr_good);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        rx_block_valid = 1'b0;
        #1;
        check_val("arst_lock", {65'd0, block_lock}, 66'd0);
        check_val("arst_outv", {65'd0, block_out_valid}, 66'd0);
        check_val("arst_out", block_out, 66'd0);
        check_val("arst_slip", {65'd0, slip}, 66'd0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int slips_before;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_lock", {65'd0, block_lock}, 66'd0);
        check_val("rst_slip", {65'd0, slip}, 66'd0);
        check_val("rst_out", block_out, 66'd0);
        check_val("rst_outv", {65'd0, block_out_valid}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition from reset on 64 clean blocks
        run_good(63);
        check_val("acq_lock63", {65'd0, block_lock}, 66'd0);
        step(1'b1, c_hdr_good);
        check_val("acq_lock64", {65'd0, block_lock}, 66'd1);
        step(1'b1, c_hdr_good);
        check_val("acq_outv65", {65'd0, block_out_valid}, 66'd1);
        check_val("acq_no_slip", slip_seen, 66'd0);

        // Unlocked: bad header on the 10th block slips once, then relock
        async_reset();
        run_good(9);
        slips_before = slip_seen;
        step(1'b1, c_hdr_bad0);
        check_val("hunt_slip", {65'd0, slip}, 66'd1);
        step(1'b1, c_hdr_bad1);
        check_val("hunt_slip_off", {65'd0, slip}, 66'd0);
        step(1'b1, c_hdr_bad0);
        run_good(63);
        check_val("hunt_lock63", {65'd0, block_lock}, 66'd0);
        run_good(1);
        check_val("hunt_lock64", {65'd0, block_lock}, 66'd1);
        check_val("hunt_slip_cnt", slip_seen - slips_before, 66'd1);

        // Locked: 15 invalid headers in a window keep lock
        for (int i = 0; i < SH_CNT_MAX; i++)
            step(1'b1, (i % 4 == 0 && i < 60) ? c_hdr_bad1 : c_hdr_good);
        check_val("inv15_lock", {65'd0, block_lock}, 66'd1);

        // Locked: 16th invalid header drops lock and slips
        for (int i = 0; i < 61; i++)
            step(1'b1, (i % 4 == 0) ? c_hdr_bad1 : c_hdr_good);
        check_val("inv16_lock", {65'd0, block_lock}, 66'd0);
        check_val("inv16_slip", {65'd0, slip}, 66'd1);
        step(1'b1, c_hdr_bad1);
        check_val("inv16_outv", {65'd0, block_out_valid}, 66'd0);
        step(1'b1, c_hdr_good);
        run_good(SH_CNT_MAX);
        check_val("relock", {65'd0, block_lock}, 66'd1);

        // Locked: one invalid header keeps lock, next clean window too
        for (int i = 0; i < SH_CNT_MAX; i++)
            step(1'b1, (i == 30) ? c_hdr_bad0 : c_hdr_good);
        check_val("inv1_lock", {65'd0, block_lock}, 66'd1);
        run_good(SH_CNT_MAX);
        check_val("clean_lock", {65'd0, block_lock}, 66'd1);

        // Acquisition with idle gaps of 1..5 cycles
        async_reset();
        for (int i = 0; i < SH_CNT_MAX; i++) begin
            step(1'b1, c_hdr_good);
            if (i == SH_CNT_MAX - 2)
                check_val("gap_lock63", {65'd0, block_lock}, 66'd0);
            repeat ($urandom_range(1, 5)) step(1'b0, c_hdr_bad1);
        end
        check_val("gap_lock64", {65'd0, block_lock}, 66'd1);

        // Reset mid-window discards progress; reacquire in exactly 64
        run_good(20);
        async_reset();
        run_good(63);
        check_val("rearm_lock63", {65'd0, block_lock}, 66'd0);
        run_good(1);
        check_val("rearm_lock64", {65'd0, block_lock}, 66'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
